// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared mode encoding, width constants and Sobel kernel weights
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_SUM    = 2'b00,
    MODE_GX     = 2'b01,
    MODE_GY     = 2'b10,
    MODE_THRESH = 2'b11
  } sobel_mode_e;

  localparam int PIX_W_DEF    = 8;
  localparam int GRAD_GUARD_W = 3;
  localparam int RES_W_DEF    = PIX_W_DEF + GRAD_GUARD_W;
  localparam int KW_W         = 3;

  // Weights indexed p1..p9 in raster order (index 0 = top-left).
  localparam logic signed [KW_W-1:0] KX [9] = '{
    -3'sd1, 3'sd0, 3'sd1,
    -3'sd2, 3'sd0, 3'sd2,
    -3'sd1, 3'sd0, 3'sd1
  };
  localparam logic signed [KW_W-1:0] KY [9] = '{
     3'sd1,  3'sd2,  3'sd1,
     3'sd0,  3'sd0,  3'sd0,
    -3'sd1, -3'sd2, -3'sd1
  };

endpackage

// File: rtl/sobel_linebuf.sv
// rtl/sobel_linebuf.sv - one-row pixel store addressed by column, read-before-write
module sobel_linebuf
  import sobel_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [PIX_W-1:0]  i_din,
  output logic [PIX_W-1:0]  o_dout
);

  logic [PIX_W-1:0] r_mem [DEPTH];

  assign o_dout = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_din;
  end

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge detector over raster pixels
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [PIX_W-1:0]              in_pix,
  input  logic                          in_sof,
  input  logic [1:0]                    mode,
  input  logic [PIX_W+GRAD_GUARD_W-1:0] thresh,
  output logic                          out_valid,
  output logic [PIX_W+GRAD_GUARD_W-1:0] out_data,
  output logic                          out_sof,
  output logic                          out_eol
);

  localparam int RES_W = PIX_W + GRAD_GUARD_W;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [RES_W-1:0] ALL_ONES = '1;

  logic [COL_W-1:0] r_col, w_col;
  logic [ROW_W-1:0] r_row, w_row;
  logic [PIX_W-1:0] w_up1, w_up2;
  sobel_mode_e      r_mode;
  logic [RES_W-1:0] r_thresh;

  // Position of the pixel being accepted this cycle; in_sof overrides the counters.
  assign w_col = in_sof ? '0 : r_col;
  assign w_row = in_sof ? '0 : r_row;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_mode   <= MODE_SUM;
      r_thresh <= '0;
    end else if (in_valid) begin
      if (in_sof) begin
        r_mode   <= sobel_mode_e'(mode);
        r_thresh <= thresh;
      end
      if (w_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end
  end

  sobel_linebuf #(.PIX_W(PIX_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb_row1 (
    .clk(clk), .i_we(in_valid), .i_addr(w_col), .i_din(in_pix), .o_dout(w_up1)
  );
  sobel_linebuf #(.PIX_W(PIX_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb_row2 (
    .clk(clk), .i_we(in_valid), .i_addr(w_col), .i_din(w_up1), .o_dout(w_up2)
  );

  logic [PIX_W-1:0] r_win [9];
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        r_win[3*r]   <= r_win[3*r+1];
        r_win[3*r+1] <= r_win[3*r+2];
      end
      r_win[2] <= w_up2;
      r_win[5] <= w_up1;
      r_win[8] <= in_pix;
    end
  end

  // Mode/thresh travel with each result so in-flight results keep their frame's settings.
  logic                    r_v0, r_v1, r_v2, r_sof0, r_sof1, r_sof2, r_eol0, r_eol1, r_eol2;
  sobel_mode_e             r_mode0, r_mode1, r_mode2;
  logic [RES_W-1:0]        r_thr0, r_thr1, r_thr2;
  logic [PIX_W-1:0]        r_p [9];
  logic signed [RES_W-1:0] w_gx, w_gy, r_gx, r_gy;
  logic [RES_W-1:0]        w_ax, w_ay, w_sum, w_res;
  logic                    r_out_valid, r_out_sof, r_out_eol;
  logic [RES_W-1:0]        r_out_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {r_v0, r_v1, r_v2, r_sof0, r_sof1, r_sof2, r_eol0, r_eol1, r_eol2} <= '0;
      {r_out_valid, r_out_sof, r_out_eol} <= '0;
      r_out_data <= '0;
    end else begin
      r_v0        <= in_valid && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
      r_sof0      <= (w_row == ROW_W'(2)) && (w_col == COL_W'(2));
      r_eol0      <= (w_col == COL_LAST);
      {r_v1, r_sof1, r_eol1} <= {r_v0, r_sof0, r_eol0};
      {r_v2, r_sof2, r_eol2} <= {r_v1, r_sof1, r_eol1};
      r_out_valid <= r_v2;
      r_out_sof   <= r_v2 && r_sof2;
      r_out_eol   <= r_v2 && r_eol2;
      r_out_data  <= r_v2 ? w_res : '0;
    end
  end

  always_ff @(posedge clk) begin
    r_mode0 <= r_mode;
    r_thr0  <= r_thresh;
    r_mode1 <= r_mode0;
    r_thr1  <= r_thr0;
    r_p     <= r_win;
    r_mode2 <= r_mode1;
    r_thr2  <= r_thr1;
    r_gx    <= w_gx;
    r_gy    <= w_gy;
  end

  always_comb begin
    w_gx = '0;
    w_gy = '0;
    for (int i = 0; i < 9; i++) begin
      w_gx = w_gx + $signed({{GRAD_GUARD_W{1'b0}}, r_p[i]}) * RES_W'(KX[i]);
      w_gy = w_gy + $signed({{GRAD_GUARD_W{1'b0}}, r_p[i]}) * RES_W'(KY[i]);
    end
  end

  assign w_ax  = r_gx[RES_W-1] ? -r_gx : r_gx;
  assign w_ay  = r_gy[RES_W-1] ? -r_gy : r_gy;
  assign w_sum = w_ax + w_ay;

  always_comb begin
    w_res = w_sum;
    case (r_mode2)
      MODE_SUM:    w_res = w_sum;
      MODE_GX:     w_res = w_ax;
      MODE_GY:     w_res = w_ay;
      MODE_THRESH: w_res = (w_sum >= r_thr2) ? ALL_ONES : '0;
      default:     w_res = w_sum;
    endcase
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sof   = r_out_sof;
  assign out_eol   = r_out_eol;

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - randomized scoreboard bench for sobel_stream
module tb_sobel_stream;

  localparam int PIX_W = 8;
  localparam int IMG_W = 16;
  localparam int IMG_H = 14;
  localparam int RES_W = PIX_W + 3;
  localparam int MAXV  = (1 << RES_W) - 1;
  localparam int NWIN  = (IMG_H - 2) * (IMG_W - 2);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [PIX_W-1:0] in_pix = '0;
  logic             in_sof = 1'b0;
  logic [1:0]       mode = '0;
  logic [RES_W-1:0] thresh = '0;
  logic             out_valid, out_sof, out_eol;
  logic [RES_W-1:0] out_data;

  sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pix(in_pix), .in_sof(in_sof),
    .mode(mode), .thresh(thresh), .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    bit sof;
    bit eol;
    int t_acc;
  } exp_t;

  exp_t sb_q[$];
  int   img [IMG_H][IMG_W];
  int   img_save [IMG_H][IMG_W];
  int   frame_mode = 0;
  int   frame_thr  = 0;
  int   n_vec = 0, n_err = 0;
  int   n_out = 0, n_sof = 0, n_eol = 0, n_nz = 0, n_1020 = 0, n_ones = 0;
  bit   log_en = 1'b0;
  int   obs_log[$];
  int   log_a[$];

  task automatic check(input string name, input int act, input int want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Result for the 3x3 window centred on (r, c) of the current frame image.
  function automatic int ref_result(input int r, input int c);
    int gx, gy, ax, ay;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1])
       - (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1]);
    ax = abs_i(gx);
    ay = abs_i(gy);
    case (frame_mode)
      0: return ax + ay;
      1: return ax;
      2: return ay;
      default: return (ax + ay >= frame_thr) ? MAXV : 0;
    endcase
  endfunction

  task automatic send_pix(input int r, input int c, input bit sof, input int gap_pct);
    exp_t e;
    while (int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom);
      in_pix   = PIX_W'($urandom);
      mode     = 2'($urandom);
      thresh   = RES_W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_sof   = sof;
    in_pix   = PIX_W'(img[r][c]);
    if (sof) begin
      mode   = 2'(frame_mode);
      thresh = RES_W'(frame_thr);
    end else begin
      mode   = 2'($urandom);
      thresh = RES_W'($urandom);
    end
    @(posedge clk); #1;
    if (r >= 2 && c >= 2) begin
      e.data  = ref_result(r - 1, c - 1);
      e.sof   = (r == 2 && c == 2);
      e.eol   = (c == IMG_W - 1);
      e.t_acc = cyc;
      sb_q.push_back(e);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // kind: 0 constant 100, 1 vertical step, 2 random, 3 replay saved image
  task automatic fill_img(input int kind);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        case (kind)
          0: img[r][c] = 100;
          1: img[r][c] = (c < IMG_W / 2) ? 0 : 255;
          2: img[r][c] = int'($urandom_range(255));
          default: img[r][c] = img_save[r][c];
        endcase
        img_save[r][c] = img[r][c];
      end
  endtask

  task automatic run_frame(input int kind, input bit sof_en, input int md, input int th,
                           input int rows, input int gap_pct);
    if (sof_en) begin
      frame_mode = md;
      frame_thr  = th;
    end
    fill_img(kind);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < IMG_W; c++)
        send_pix(r, c, sof_en && r == 0 && c == 0, gap_pct);
  endtask

  task automatic clear_counts();
    n_out = 0; n_sof = 0; n_eol = 0; n_nz = 0; n_1020 = 0; n_ones = 0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (4) @(negedge clk);
    check({name, "_drained"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  exp_t m_e;
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got data %0d, expected no output (cycle %0d)", out_data, cyc);
      end else begin
        m_e = sb_q.pop_front();
        check("out_data", int'(out_data), m_e.data);
        check("out_sof", int'(out_sof), int'(m_e.sof));
        check("out_eol", int'(out_eol), int'(m_e.eol));
        check("latency", cyc, m_e.t_acc + 3);
      end
      n_out++;
      n_sof  += int'(out_sof);
      n_eol  += int'(out_eol);
      n_nz   += (out_data != 0) ? 1 : 0;
      n_1020 += (out_data == 1020) ? 1 : 0;
      n_ones += (int'(out_data) == MAXV) ? 1 : 0;
      if (log_en) obs_log.push_back(int'(out_data));
    end else begin
      check("idle_data_zero", int'(out_data), 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int md, th, rst_cyc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sof", int'(out_sof), 0);
    check("rst_out_eol", int'(out_eol), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    clear_counts();
    run_frame(0, 1'b1, 0, 0, IMG_H, 0);
    drain("const");
    check("const_n_out", n_out, NWIN);
    check("const_n_sof", n_sof, 1);
    check("const_n_eol", n_eol, IMG_H - 2);
    check("const_n_nonzero", n_nz, 0);

    for (int m = 0; m < 2; m++) begin
      clear_counts();
      run_frame(1, 1'b1, m, 0, IMG_H, 0);
      drain("step_sum_gx");
      check("step_n_1020", n_1020, 2 * (IMG_H - 2));
      check("step_n_nonzero", n_nz, 2 * (IMG_H - 2));
    end
    clear_counts();
    run_frame(1, 1'b1, 2, 0, IMG_H, 0);
    drain("step_gy");
    check("step_gy_nonzero", n_nz, 0);
    clear_counts();
    run_frame(1, 1'b1, 3, 1020, IMG_H, 0);
    drain("step_thr1020");
    check("thr1020_n_ones", n_ones, 2 * (IMG_H - 2));
    check("thr1020_n_nonzero", n_nz, 2 * (IMG_H - 2));
    clear_counts();
    run_frame(1, 1'b1, 3, 1021, IMG_H, 0);
    drain("step_thr1021");
    check("thr1021_n_nonzero", n_nz, 0);

    md = int'($urandom_range(3));
    th = int'($urandom_range(1500));
    obs_log.delete();
    log_en = 1'b1;
    run_frame(2, 1'b1, md, th, IMG_H, 0);
    drain("nogap");
    log_a = obs_log;
    obs_log.delete();
    run_frame(3, 1'b1, md, th, IMG_H, 35);
    drain("gap");
    log_en = 1'b0;
    check("gap_log_len", obs_log.size(), log_a.size());
    for (int i = 0; i < log_a.size() && i < obs_log.size(); i++)
      check("gap_log_data", obs_log[i], log_a[i]);

    clear_counts();
    run_frame(2, 1'b1, 0, 0, 10, 0);
    run_frame(2, 1'b1, 3, int'($urandom_range(800)), IMG_H, 10);
    drain("midsof");
    check("midsof_n_out", n_out, 8 * (IMG_W - 2) + NWIN);
    check("midsof_n_sof", n_sof, 2);
    check("midsof_n_eol", n_eol, 8 + IMG_H - 2);

    frame_mode = 1;
    fill_img(2);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < IMG_W; c++) begin
        if (r == 6 && c == 9) break;
        send_pix(r, c, r == 0 && c == 0, 0);
      end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_cyc = cyc;
    while (sb_q.size() > 0 && sb_q[$].t_acc + 3 >= rst_cyc) void'(sb_q.pop_back());
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("midrst_drained", sb_q.size(), 0);
    clear_counts();
    run_frame(2, 1'b1, 0, 0, IMG_H, 0);
    run_frame(2, 1'b0, 0, 0, IMG_H, 0);
    drain("postrst");
    check("postrst_n_out", n_out, 2 * NWIN);
    check("postrst_n_sof", n_sof, 2);
    check("postrst_n_eol", n_eol, 2 * (IMG_H - 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
